// File: rtl/add_mp_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_mp_seq
// Description : Multi-precision add/subtract sequencer. Streams NWORDS 32-bit
//               limbs, least-significant first, through one shared external
//               registered 32-bit adder and chains the adder's registered
//               carry-out into the next limb's carry-in.
// Ports       : clk, rst (async, active-low)
//               in_valid/in_ready, in_a, in_b, in_cin, in_sub  - operand side
//               out_valid/out_ready, out_sum, out_cout          - result side
//               busy                                            - RUN or DONE
//               add_en, add_a, add_b, add_cin -> adder inputs
//               add_sum, add_cout             <- adder registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module add_mp_seq #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NWORDS*32-1:0]   in_a,
    input  logic [NWORDS*32-1:0]   in_b,
    input  logic                   in_cin,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NWORDS*32-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy,
    output logic                   add_en,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    output logic                   add_cin,
    input  logic [31:0]            add_sum,
    input  logic                   add_cout
);

    // Index runs 0..NWORDS: values below NWORDS are issue cycles, NWORDS is
    // the trailing capture-only cycle.
    localparam int c_IDXW = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_IDXW-1:0]       r_idx;
    logic [NWORDS*32-1:0]    r_a;
    logic [NWORDS*32-1:0]    r_b;     // effective B (already inverted for subtract)
    logic                    r_sub;
    logic                    r_cin;   // effective carry-in for limb 0
    logic [NWORDS*32-1:0]    r_sum;
    logic                    r_cout;

    logic                    w_issue;
    logic [31:0]             w_a;
    logic [31:0]             w_b;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

    assign w_issue = (r_state == S_RUN) && (r_idx < c_IDXW'(NWORDS));

    // Limb select for the current issue index.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (r_idx == c_IDXW'(k)) begin
                w_a = r_a[32*k +: 32];
                w_b = r_b[32*k +: 32];
            end
        end
    end

    // Adder drive is combinational from state so the limb is presented in the
    // same cycle it is issued. For k>0 the carry comes straight from the
    // adder's registered carry-out of limb k-1.
    assign add_en  = w_issue;
    assign add_a   = w_issue ? w_a : 32'd0;
    assign add_b   = w_issue ? w_b : 32'd0;
    assign add_cin = w_issue && ((r_idx == '0) ? r_cin : add_cout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_cin   <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_sub   <= in_sub;
                        r_cin   <= in_sub | in_cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // add_sum carries limb idx-1 (one-cycle adder latency).
                    for (int k = 0; k < NWORDS; k++) begin
                        if (r_idx == c_IDXW'(k + 1)) begin
                            r_sum[32*k +: 32] <= add_sum;
                        end
                    end
                    if (r_idx == c_IDXW'(NWORDS)) begin
                        // Subtract reports borrow, the inverse of the carry.
                        r_cout  <= add_cout ^ r_sub;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
